// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit that owns the MIPS HI/LO registers.
// Define MULDIV_HILO_WRITE_EN to add the MTHI/MTLO write port (hi_we_i, lo_we_i, wdata_i).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
`ifdef MULDIV_HILO_WRITE_EN
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_q, dbz_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     in1_abs, in2_abs;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_shift;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_new;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    assign signed_op = ~op_i[0];
    assign in1_abs   = (signed_op && in1_i[WIDTH-1]) ? -in1_i : in1_i;
    assign in2_abs   = (signed_op && in2_i[WIDTH-1]) ? -in2_i : in2_i;

    // work_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, work_q[WIDTH-1:1]};

    assign rem_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, opnd_q};
    assign rem_new   = rem_ge ? (rem_shift[WIDTH-1:0] - opnd_q) : rem_shift[WIDTH-1:0];
    assign div_next  = {rem_new, work_q[WIDTH-2:0], rem_ge};

    assign prod_fix  = neg_res_q ? -work_q : work_q;
    assign quot_fix  = neg_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    assign rem_fix   = neg_rem_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    is_div_d = op_i[1];
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    if (op_i[1] && (in2_i == '0)) begin
                        // Divide by zero bypasses CALC; FINISH passes work_q through unchanged
                        dbz_d     = 1'b1;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        work_d    = {in1_i, {WIDTH{1'b1}}};
                        state_d   = FINISH;
                    end else begin
                        neg_res_d = signed_op && (in1_i[WIDTH-1] ^ in2_i[WIDTH-1]);
                        neg_rem_d = signed_op && op_i[1] && in1_i[WIDTH-1];
                        opnd_d    = in2_abs;
                        work_d    = {{WIDTH{1'b0}}, in1_abs};
                        state_d   = CALC;
                    end
                end
`ifdef MULDIV_HILO_WRITE_EN
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
`endif
            end
            CALC: begin
                work_d = is_div_q ? div_next : mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
            end
            FINISH: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            work_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            work_q    <= work_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table of directed vectors plus
// hand-written sequences for ignored starts, back-to-back issue and mid-op reset.
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [1:0]    op_i;
    logic [W-1:0]  in1_i;
    logic [W-1:0]  in2_i;
`ifdef MULDIV_HILO_WRITE_EN
    logic          hi_we_i = 1'b0;
    logic          lo_we_i = 1'b0;
    logic [W-1:0]  wdata_i = '0;
`endif
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;
    logic          div_by_zero_o;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .op_i          (op_i),
        .in1_i         (in1_i),
        .in2_i         (in2_i),
`ifdef MULDIV_HILO_WRITE_EN
        .hi_we_i       (hi_we_i),
        .lo_we_i       (lo_we_i),
        .wdata_i       (wdata_i),
`endif
        .busy_o        (busy_o),
        .done_o        (done_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         edbz;
        int           lat;
    } vec_t;

    vec_t vecs[14];
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives a request away from the edge and returns #1 after the accepting edge
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start_i = 1'b1;
        op_i    = op;
        in1_i   = a;
        in2_i   = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic waitDone(output int lat, output logic busyOk);
        lat    = 0;
        busyOk = 1'b1;
        while (!done_o && lat < 100) begin
            if (!busy_o) busyOk = 1'b0;
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic        busyOk;
        int          donePulses;
        logic [W-1:0] prevHi, prevLo;

        vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[5]  = '{DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
        vecs[6]  = '{MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33};
        vecs[7]  = '{MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33};
        vecs[8]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[9]  = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1};
        vecs[10] = '{DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33};
        vecs[11] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
        vecs[12] = '{DIVU,  32'd5,        32'd10,       32'd5,        32'd0,        1'b0, 33};
        vecs[13] = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33};

        reset_i = 1'b1;
        start_i = 1'b0;
        op_i    = '0;
        in1_i   = '0;
        in2_i   = '0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        checkOutput("reset done", 64'(done_o), 64'd0);
        checkOutput("reset hi", 64'(hi_o), 64'd0);
        checkOutput("reset lo", 64'(lo_o), 64'd0);
        checkOutput("reset dbz", 64'(div_by_zero_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clk_i);

        // Each new request is issued in the done cycle of the previous one
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("v%0d dbz at accept", i), 64'(div_by_zero_o), 64'(vecs[i].edbz));
            waitDone(lat, busyOk);
            checkOutput($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            checkOutput($sformatf("v%0d busy in flight", i), 64'(busyOk), 64'd1);
            checkOutput($sformatf("v%0d busy at done", i), 64'(busy_o), 64'd0);
            checkOutput($sformatf("v%0d hi", i), 64'(hi_o), 64'(vecs[i].eh));
            checkOutput($sformatf("v%0d lo", i), 64'(lo_o), 64'(vecs[i].el));
            checkOutput($sformatf("v%0d dbz", i), 64'(div_by_zero_o), 64'(vecs[i].edbz));
        end
        prevHi = vecs[13].eh;
        prevLo = vecs[13].el;

        // Start during CALC must be ignored and leave HI/LO untouched
        applyStimulus(MULT, 32'd1000, 32'd3000);
        repeat (10) @(posedge clk_i);
        #1;
        applyStimulus(DIVU, 32'd5, 32'd0);
        checkOutput("ignored start hi held", 64'(hi_o), 64'(prevHi));
        checkOutput("ignored start lo held", 64'(lo_o), 64'(prevLo));
        checkOutput("ignored start dbz", 64'(div_by_zero_o), 64'd0);
        checkOutput("ignored start busy", 64'(busy_o), 64'd1);
        waitDone(lat, busyOk);
        checkOutput("ignored start latency", 64'(lat), 64'd22);
        checkOutput("ignored start hi", 64'(hi_o), 64'd0);
        checkOutput("ignored start lo", 64'(lo_o), 64'h002DC6C0);

        applyStimulus(MULTU, 32'd6, 32'd7);
        checkOutput("b2b done cleared", 64'(done_o), 64'd0);
        checkOutput("b2b busy", 64'(busy_o), 64'd1);
        waitDone(lat, busyOk);
        checkOutput("b2b latency", 64'(lat), 64'd33);
        checkOutput("b2b lo", 64'(lo_o), 64'd42);
        checkOutput("b2b hi", 64'(hi_o), 64'd0);

        // Reset mid-CALC aborts with no late done pulse
        applyStimulus(MULT, 32'd3, 32'd5);
        repeat (5) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("midreset busy", 64'(busy_o), 64'd0);
        checkOutput("midreset done", 64'(done_o), 64'd0);
        checkOutput("midreset hi", 64'(hi_o), 64'd0);
        checkOutput("midreset lo", 64'(lo_o), 64'd0);
        reset_i    = 1'b0;
        donePulses = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (done_o) donePulses++;
        end
        checkOutput("midreset late done", 64'(donePulses), 64'd0);
        checkOutput("midreset lo after", 64'(lo_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
